stack_op_controller: RTL and testbench

Command sequencer in front of the `stack_alu_integration` datapath. It accepts one macro command at a time (PUSH, POP, DUP, binary ALU op) over a valid/ready handshake. It expands each command into the cycle-by-cycle `stackAction`/`aluCode`/`in_val` sequence the datapath needs, tracks stack occupancy to reject overflow and underflow, and returns a one-cycle response carrying the result.

---
 rtl/stack_op_if.sv | 36 +++
 rtl/stack_op_controller.sv | 214 +++++++++++++++++++++
 tb/tb_stack_op_controller.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_op_if.sv
// Command/response and datapath-drive signals of stack_op_controller.
// The slave modport is the controller; the master modport is the requester plus datapath.
interface stack_op_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [2:0]       cmd_alu;
    logic [WIDTH-1:0] cmd_data;
    logic [3:0]       stack_action;
    logic [2:0]       alu_code;
    logic [WIDTH-1:0] stack_in;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] alu_result;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [DW-1:0]    depth;
    logic [7:0]       err_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_alu, cmd_data, top, alu_result,
        output cmd_ready, stack_action, alu_code, stack_in,
               rsp_valid, rsp_data, rsp_err, depth, err_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_alu, cmd_data, top, alu_result,
        input  cmd_ready, stack_action, alu_code, stack_in,
               rsp_valid, rsp_data, rsp_err, depth, err_count
    );
endinterface

// File: rtl/stack_op_controller.sv
// Expands PUSH/POP/DUP/ALU macro commands into per-cycle stack datapath actions.
// Optional: define STACK_CTRL_ERRCNT_EN to build the saturating rejected-command counter.
module stack_op_controller #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    stack_op_if.slave bus
);
    localparam int            DW        = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0] ONE       = DW'(1);
    localparam logic [DW-1:0] TWO       = DW'(2);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [1:0] OP_DUP  = 2'b11;

    localparam logic [3:0] ACT_PUSH = 4'b1000;
    localparam logic [3:0] ACT_POP  = 4'b0001;
    localparam logic [3:0] ACT_HOLD = 4'b0000;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_PUSH   = 4'd1,
        S_POP    = 4'd2,
        S_ALU    = 4'd3,
        S_POP_A  = 4'd4,
        S_POP_B  = 4'd5,
        S_PUSH_R = 4'd6,
        S_DUP    = 4'd7,
        S_RESP   = 4'd8
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             legal_s;
    logic             accept_s;
    logic             ready_s;
    logic             rsp_valid_s;
    logic [3:0]       action_s;
    logic [WIDTH-1:0] stack_in_s;
    logic [2:0]       code_r;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_err_r;
    logic [DW-1:0]    depth_r;

    assign accept_s = (state_r == S_IDLE) && bus.cmd_valid;

    // Occupancy check of the offered command against the current depth
    always_comb begin
        legal_s = 1'b0;
        case (bus.cmd_op)
            OP_PUSH: legal_s = (depth_r < DEPTH_MAX);
            OP_POP:  legal_s = (depth_r >= ONE);
            OP_ALU:  legal_s = (depth_r >= TWO);
            OP_DUP:  legal_s = (depth_r >= ONE) && (depth_r < DEPTH_MAX);
            default: legal_s = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-state datapath drive
    always_comb begin
        state_s     = state_r;
        ready_s     = 1'b0;
        rsp_valid_s = 1'b0;
        action_s    = ACT_HOLD;
        stack_in_s  = '0;
        case (state_r)
            S_IDLE: begin
                ready_s = 1'b1;
                if (bus.cmd_valid) begin
                    if (!legal_s) begin
                        state_s = S_RESP;
                    end else begin
                        case (bus.cmd_op)
                            OP_PUSH: state_s = S_PUSH;
                            OP_POP:  state_s = S_POP;
                            OP_ALU:  state_s = S_ALU;
                            OP_DUP:  state_s = S_DUP;
                            default: state_s = S_RESP;
                        endcase
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PUSH: begin
                action_s   = ACT_PUSH;
                stack_in_s = data_r;
                state_s    = S_RESP;
            end
            S_POP: begin
                action_s = ACT_POP;
                state_s  = S_RESP;
            end
            S_DUP: begin
                // top is forwarded combinationally so the datapath pushes a copy of itself
                action_s   = ACT_PUSH;
                stack_in_s = bus.top;
                state_s    = S_RESP;
            end
            S_ALU:   state_s = S_POP_A;
            S_POP_A: begin
                action_s = ACT_POP;
                state_s  = S_POP_B;
            end
            S_POP_B: begin
                action_s = ACT_POP;
                state_s  = S_PUSH_R;
            end
            S_PUSH_R: begin
                action_s   = ACT_PUSH;
                stack_in_s = result_r;
                state_s    = S_RESP;
            end
            S_RESP: begin
                rsp_valid_s = 1'b1;
                state_s     = S_IDLE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Command latch at handshake; verdict of the legality check kept for the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_r    <= 3'b000;
            data_r    <= '0;
            rsp_err_r <= 1'b0;
        end else if (accept_s) begin
            code_r    <= bus.cmd_alu;
            data_r    <= bus.cmd_data;
            rsp_err_r <= ~legal_s;
        end else begin
            code_r    <= code_r;
            data_r    <= data_r;
            rsp_err_r <= rsp_err_r;
        end
    end

    // Occupancy tracking and result capture, mirroring the action issued each cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_r    <= '0;
            result_r   <= '0;
            rsp_data_r <= '0;
        end else begin
            case (state_r)
                S_PUSH: begin
                    rsp_data_r <= data_r;
                    depth_r    <= depth_r + ONE;
                end
                S_POP: begin
                    rsp_data_r <= bus.top;
                    depth_r    <= depth_r - ONE;
                end
                S_DUP: begin
                    rsp_data_r <= bus.top;
                    depth_r    <= depth_r + ONE;
                end
                S_ALU:   result_r <= bus.alu_result;
                S_POP_A: depth_r  <= depth_r - ONE;
                S_POP_B: depth_r  <= depth_r - ONE;
                S_PUSH_R: begin
                    rsp_data_r <= result_r;
                    depth_r    <= depth_r + ONE;
                end
                default: depth_r <= depth_r;
            endcase
        end
    end

`ifdef STACK_CTRL_ERRCNT_EN
    logic [7:0] err_count_r;

    // Saturating count of rejected commands, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_r <= 8'd0;
        end else if (accept_s && !legal_s && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'd1;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign bus.err_count = err_count_r;
`else
    assign bus.err_count = 8'd0;
`endif

    assign bus.cmd_ready    = ready_s;
    assign bus.rsp_valid    = rsp_valid_s;
    assign bus.stack_action = action_s;
    assign bus.stack_in     = stack_in_s;
    assign bus.alu_code     = code_r;
    assign bus.rsp_data     = rsp_data_r;
    assign bus.rsp_err      = rsp_err_r;
    assign bus.depth        = depth_r;
endmodule

// File: tb/tb_stack_op_controller.sv
// Bench for stack_op_controller: behavioural stack datapath plus a command-level
// queue model predicting each response, its latency, occupancy and error count.
module tb_stack_op_controller;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH + 1);
    localparam int RW    = 1 + 4 + 3 + WIDTH + 1 + WIDTH + 1 + DW + 8;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [1:0] OP_DUP  = 2'b11;

    typedef struct {
        logic             err;
        logic [WIDTH-1:0] data;
        int               lat;
        logic             saw_pop;
        logic [WIDTH-1:0] push_val;
        logic             ready_after;
        logic             rv_after;
    } obs_t;

    typedef struct {
        logic             err;
        logic [WIDTH-1:0] data;
        int               lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stack_op_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    stack_op_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Datapath ALU: a = top, b = next
    function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] c, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (c)
            3'd0:    return a + b;
            3'd1:    return b - a;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    // Behavioural datapath stack sharing rst with the controller
    logic [WIDTH-1:0] dp_mem [0:15];
    logic [3:0]       dp_sp;
    int               dp_bad = 0;
    logic [WIDTH-1:0] dp_top, dp_next;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_sp <= 4'd0;
        end else if (bus.stack_action == 4'b1000) begin
            if (dp_sp < 4'(DEPTH)) begin
                dp_mem[dp_sp] <= bus.stack_in;
                dp_sp <= dp_sp + 4'd1;
            end else dp_bad <= dp_bad + 1;
        end else if (bus.stack_action == 4'b0001) begin
            if (dp_sp > 4'd0) dp_sp <= dp_sp - 4'd1;
            else dp_bad <= dp_bad + 1;
        end
    end

    always_comb begin
        dp_top  = (dp_sp > 4'd0) ? dp_mem[dp_sp - 4'd1] : '0;
        dp_next = (dp_sp > 4'd1) ? dp_mem[dp_sp - 4'd2] : '0;
    end

    assign bus.top        = dp_top;
    assign bus.alu_result = alu_f(bus.alu_code, dp_top, dp_next);

    // Command-level reference model
    logic [WIDTH-1:0] mstack[$];
    logic [WIDTH-1:0] mlast;
    int               merr;

    task automatic model_reset();
        mstack.delete();
        mlast = '0;
        merr  = 0;
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [2:0] alu, input logic [WIDTH-1:0] data,
                             output exp_t e);
        logic [WIDTH-1:0] a, b;
        e.err = 1'b0;
        e.lat = 2;
        e.data = mlast;
        if (op == OP_PUSH && mstack.size() < DEPTH) begin
            mstack.push_back(data);
            e.data = data;
        end else if (op == OP_POP && mstack.size() >= 1) begin
            e.data = mstack.pop_back();
        end else if (op == OP_DUP && mstack.size() >= 1 && mstack.size() < DEPTH) begin
            e.data = mstack[$];
            mstack.push_back(e.data);
        end else if (op == OP_ALU && mstack.size() >= 2) begin
            a = mstack.pop_back();
            b = mstack.pop_back();
            e.data = alu_f(alu, a, b);
            mstack.push_back(e.data);
            e.lat = 5;
        end else begin
            e.err = 1'b1;
            e.lat = 1;
            merr++;
        end
        mlast = e.data;
    endtask

    function automatic logic [7:0] exp_errcnt();
`ifdef STACK_CTRL_ERRCNT_EN
        return (merr > 255) ? 8'hFF : 8'(merr);
`else
        return 8'd0;
`endif
    endfunction

    function automatic logic [RW-1:0] reset_vec();
        return {1'b1, 4'b0000, 3'b000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'h0, 8'h00};
    endfunction

    function automatic logic [RW-1:0] out_vec();
        return {bus.cmd_ready, bus.stack_action, bus.alu_code, bus.stack_in, bus.rsp_valid,
                bus.rsp_data, bus.rsp_err, bus.depth, bus.err_count};
    endfunction

    // Issues one command from a negedge and observes it up to the cycle after the response
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] alu, input logic [WIDTH-1:0] data,
                          output obs_t o);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_alu   = alu;
        bus.cmd_data  = data;
        @(posedge clk);
        o.err = 1'b0; o.data = '0; o.lat = 0; o.saw_pop = 1'b0; o.push_val = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (bus.stack_action == 4'b0001) o.saw_pop = 1'b1;
            if (bus.stack_action == 4'b1000) o.push_val = bus.stack_in;
            if (bus.rsp_valid === 1'b1) begin
                o.lat  = c;
                o.data = bus.rsp_data;
                o.err  = bus.rsp_err;
                break;
            end
        end
        @(negedge clk);
        o.ready_after = bus.cmd_ready;
        o.rv_after    = bus.rsp_valid;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (out_vec() !== reset_vec()) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", out_vec(), reset_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_push_alu();
        obs_t o; exp_t e;
        do_cmd(OP_PUSH, 3'd0, 16'h000A, o); model_cmd(OP_PUSH, 3'd0, 16'h000A, e);
        checks++;
        if (o.data !== 16'h000A || o.err !== 1'b0 || o.lat != 2) begin
            errors++; $display("FAIL push_a got %h/%b/%0d exp 000a/0/2", o.data, o.err, o.lat);
        end
        checks++;
        if (o.ready_after !== 1'b1 || o.rv_after !== 1'b0) begin
            errors++; $display("FAIL push_a_ready got rdy %b rv %b exp 1 0", o.ready_after, o.rv_after);
        end
        do_cmd(OP_PUSH, 3'd0, 16'h0005, o); model_cmd(OP_PUSH, 3'd0, 16'h0005, e);
        checks++;
        if (o.data !== 16'h0005 || o.err !== 1'b0) begin
            errors++; $display("FAIL push_b got %h/%b exp 0005/0", o.data, o.err);
        end
        do_cmd(OP_ALU, 3'd0, 16'h0000, o); model_cmd(OP_ALU, 3'd0, 16'h0000, e);
        checks++;
        if (o.data !== 16'h000F || o.err !== 1'b0 || o.lat != 5) begin
            errors++; $display("FAIL alu_add got %h/%b/%0d exp 000f/0/5", o.data, o.err, o.lat);
        end
        checks++;
        if (bus.depth !== 4'd1 || bus.top !== 16'h000F) begin
            errors++; $display("FAIL alu_add_state got depth %0d top %h exp 1 000f", bus.depth, bus.top);
        end
    endtask

    task automatic test_pop_underflow();
        obs_t o; exp_t e;
        do_cmd(OP_POP, 3'd0, 16'h0, o); model_cmd(OP_POP, 3'd0, 16'h0, e);
        checks++;
        if (o.data !== 16'h000F || o.err !== 1'b0 || bus.depth !== 4'd0) begin
            errors++; $display("FAIL pop got %h/%b depth %0d exp 000f/0 depth 0", o.data, o.err, bus.depth);
        end
        do_cmd(OP_POP, 3'd0, 16'h0, o); model_cmd(OP_POP, 3'd0, 16'h0, e);
        checks++;
        if (o.err !== 1'b1 || o.saw_pop !== 1'b0 || bus.depth !== 4'd0 || o.lat != 1 || o.data !== 16'h000F) begin
            errors++;
            $display("FAIL pop_empty got err %b pop %b depth %0d lat %0d data %h exp 1 0 0 1 000f",
                     o.err, o.saw_pop, bus.depth, o.lat, o.data);
        end
    endtask

    task automatic test_alu_underflow();
        obs_t o; exp_t e;
        do_cmd(OP_PUSH, 3'd0, 16'h0003, o); model_cmd(OP_PUSH, 3'd0, 16'h0003, e);
        do_cmd(OP_ALU, 3'd0, 16'h0, o); model_cmd(OP_ALU, 3'd0, 16'h0, e);
        checks++;
        if (o.err !== 1'b1 || o.lat != 1 || bus.depth !== 4'd1) begin
            errors++; $display("FAIL alu_underflow got err %b lat %0d depth %0d exp 1 1 1", o.err, o.lat, bus.depth);
        end
        checks++;
        if (bus.err_count !== exp_errcnt()) begin
            errors++; $display("FAIL err_count got %0d exp %0d", bus.err_count, exp_errcnt());
        end
    endtask

    task automatic test_overflow();
        obs_t o; exp_t e;
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            do_cmd(OP_PUSH, 3'd0, 16'(i), o); model_cmd(OP_PUSH, 3'd0, 16'(i), e);
        end
        do_cmd(OP_PUSH, 3'd0, 16'h0009, o); model_cmd(OP_PUSH, 3'd0, 16'h0009, e);
        checks++;
        if (o.err !== 1'b1 || bus.depth !== 4'd8 || o.data !== 16'h0008) begin
            errors++; $display("FAIL push_full got err %b depth %0d data %h exp 1 8 0008", o.err, bus.depth, o.data);
        end
        do_cmd(OP_DUP, 3'd0, 16'h0, o); model_cmd(OP_DUP, 3'd0, 16'h0, e);
        checks++;
        if (o.err !== 1'b1 || bus.depth !== 4'd8) begin
            errors++; $display("FAIL dup_full got err %b depth %0d exp 1 8", o.err, bus.depth);
        end
    endtask

    task automatic test_dup_alu();
        obs_t o; exp_t e;
        apply_reset();
        do_cmd(OP_PUSH, 3'd0, 16'h0007, o); model_cmd(OP_PUSH, 3'd0, 16'h0007, e);
        do_cmd(OP_DUP, 3'd0, 16'h0, o); model_cmd(OP_DUP, 3'd0, 16'h0, e);
        checks++;
        if (o.push_val !== 16'h0007 || bus.depth !== 4'd2 || o.data !== 16'h0007 || o.err !== 1'b0) begin
            errors++;
            $display("FAIL dup got stack_in %h depth %0d data %h err %b exp 0007 2 0007 0",
                     o.push_val, bus.depth, o.data, o.err);
        end
        do_cmd(OP_ALU, 3'd0, 16'h0, o); model_cmd(OP_ALU, 3'd0, 16'h0, e);
        checks++;
        if (o.data !== 16'h000E || o.err !== 1'b0) begin
            errors++; $display("FAIL dup_alu got %h/%b exp 000e/0", o.data, o.err);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o; exp_t e;
        logic rv_seen = 1'b0;
        do_cmd(OP_PUSH, 3'd0, 16'h0001, o); model_cmd(OP_PUSH, 3'd0, 16'h0001, e);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_ALU; bus.cmd_alu = 3'd1; bus.cmd_data = '0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stack_action !== 4'b0001) begin
            errors++; $display("FAIL pop_a_action got %b exp 0001", bus.stack_action);
        end
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (out_vec() !== reset_vec()) begin
            errors++; $display("FAIL reset_mid got %h exp %h", out_vec(), reset_vec());
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 1) rst = 1'b0;
            if (bus.rsp_valid !== 1'b0) rv_seen = 1'b1;
        end
        checks++;
        if (rv_seen !== 1'b0) begin
            errors++; $display("FAIL reset_mid_rsp got rsp_valid 1 exp 0");
        end
        do_cmd(OP_PUSH, 3'd0, 16'h0001, o); model_cmd(OP_PUSH, 3'd0, 16'h0001, e);
        checks++;
        if (o.data !== 16'h0001 || o.err !== 1'b0 || bus.depth !== 4'd1) begin
            errors++; $display("FAIL push_after_reset got %h/%b depth %0d exp 0001/0 1", o.data, o.err, bus.depth);
        end
    endtask

    task automatic test_random();
        obs_t o; exp_t e;
        logic [1:0] op;
        logic [2:0] alu;
        logic [WIDTH-1:0] data;
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = OP_PUSH;
                4, 5:       op = OP_POP;
                6, 7:       op = OP_ALU;
                default:    op = OP_DUP;
            endcase
            alu  = 3'($urandom_range(0, 7));
            data = 16'($urandom);
            do_cmd(op, alu, data, o);
            model_cmd(op, alu, data, e);
            checks++;
            if (o.err !== e.err || o.data !== e.data || o.lat != e.lat) begin
                errors++;
                $display("FAIL rand_rsp[%0d] op %0d got %h/%b/%0d exp %h/%b/%0d",
                         i, op, o.data, o.err, o.lat, e.data, e.err, e.lat);
            end
            checks++;
            if (bus.depth !== DW'(mstack.size()) || bus.depth > DW'(DEPTH) || bus.err_count !== exp_errcnt()) begin
                errors++;
                $display("FAIL rand_state[%0d] got depth %0d errcnt %0d exp %0d %0d",
                         i, bus.depth, bus.err_count, mstack.size(), exp_errcnt());
            end
            checks++;
            if (o.ready_after !== 1'b1 || o.rv_after !== 1'b0) begin
                errors++; $display("FAIL rand_ready[%0d] got rdy %b rv %b exp 1 0", i, o.ready_after, o.rv_after);
            end
        end
        checks++;
        if (dp_bad != 0) begin
            errors++; $display("FAIL datapath_misuse got %0d exp 0", dp_bad);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_alu   = 3'b000;
        bus.cmd_data  = '0;
        test_reset();
        test_push_alu();
        test_pop_underflow();
        test_alu_underflow();
        test_overflow();
        test_dup_alu();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
